// File: rtl/lfsr_sched_pkg.sv
// Shared types, constants and the generator tap function for the LFSR scheduler.
package lfsr_sched_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_e;

    // Word that forces the generator back to its seed once it has been handed out.
    localparam logic [63:0] TERM_WORD    = 64'h9C69_8321_9672_4182;
    localparam logic [63:0] DEFAULT_SEED = 64'hFFFF_FFFF_FFFF_FFFF;

    // One generator step for the fixed 64-bit tap set.
    function automatic logic [63:0] lfsr_step(input logic [63:0] q);
        return {q[62] ^ q[61], q[61] ^ q[60], q[60] ^ q[59], q[59] ^ q[58], q[58:0], q[63]};
    endfunction

endpackage

// File: rtl/lfsr64_core.sv
// 64-bit generator register: loads, steps, and reloads the seed after the terminal word.
module lfsr64_core
    import lfsr_sched_pkg::*;
#(
    parameter logic [63:0] SEED = DEFAULT_SEED
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        step_en,
    input  logic        load_en,
    input  logic [63:0] load_val,
    output logic [63:0] q,
    output logic        term
);

    logic [63:0] q_d;
    logic [63:0] q_q;

    // Next generator value: an explicit load wins, otherwise step (or reload after the terminal word).
    always_comb begin
        q_d = q_q;
        if (load_en) begin
            q_d = load_val;
        end else if (step_en) begin
            if (q_q == TERM_WORD) begin
                q_d = SEED;
            end else begin
                q_d = lfsr_step(q_q);
            end
        end else begin
            q_d = q_q;
        end
    end

    // Generator state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            q_q <= SEED;
        end else begin
            q_q <= q_d;
        end
    end

    assign q    = q_q;
    assign term = (q_q == TERM_WORD);

endmodule

// File: rtl/lfsr_rr_scheduler.sv
// Round-robin scheduler handing out bursts of generator words over a valid/ready channel.
module lfsr_rr_scheduler
    import lfsr_sched_pkg::*;
#(
    parameter int          NREQ      = 4,
    parameter int          WIDTH     = 64,
    parameter int          BURST_MAX = 8,
    parameter int          LENW      = 4,
    parameter logic [63:0] SEED      = DEFAULT_SEED
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*LENW-1:0]   burst_len,
    output logic [NREQ-1:0]        gnt,
    output logic                   rd_valid,
    input  logic                   rd_ready,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   rd_last,
    input  logic                   seed_load,
    input  logic [WIDTH-1:0]       seed_value,
    output logic                   busy,
    output logic [15:0]            wrap_count
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_e            state_q, state_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic              valid_q, valid_d;
    logic              last_q, last_d;
    logic              busy_q, busy_d;
    logic [IW-1:0]     rr_q, rr_d;
    logic [IW-1:0]     owner_q, owner_d;
    logic [LENW-1:0]   beats_q, beats_d;
    logic [15:0]       wrap_q, wrap_d;

    logic              pick_found_s;
    logic [IW-1:0]     pick_idx_s;
    logic [IW:0]       sum_s;
    logic [LENW-1:0]   raw_len_s;
    logic [LENW-1:0]   pick_len_s;
    logic              accept_s;
    logic              load_en_s;
    logic [63:0]       load_val_s;
    logic [63:0]       gen_q_s;
    logic              term_s;

    assign accept_s   = valid_q & rd_ready;
    assign load_en_s  = (state_q == IDLE) & seed_load;
    // An all-zero seed would lock the generator up, so it is replaced by the default seed.
    assign load_val_s = (seed_value == 64'd0) ? SEED : seed_value;

    lfsr64_core #(.SEED(SEED)) u_core (
        .clock    (clock),
        .reset    (reset),
        .step_en  (accept_s),
        .load_en  (load_en_s),
        .load_val (load_val_s),
        .q        (gen_q_s),
        .term     (term_s)
    );

    // Find the first requesting index at or after the round-robin pointer, wrapping modulo NREQ.
    always_comb begin
        pick_found_s = 1'b0;
        pick_idx_s   = '0;
        sum_s        = '0;
        for (int k = 0; k < NREQ; k++) begin
            sum_s = {1'b0, rr_q} + (IW+1)'(k);
            if (sum_s >= (IW+1)'(NREQ)) begin
                sum_s = sum_s - (IW+1)'(NREQ);
            end else begin
                sum_s = sum_s;
            end
            if (!pick_found_s && req[sum_s[IW-1:0]]) begin
                pick_found_s = 1'b1;
                pick_idx_s   = sum_s[IW-1:0];
            end else begin
                pick_found_s = pick_found_s;
            end
        end
    end

    // Burst length of the picked requester: zero means one word, oversize is clamped.
    always_comb begin
        raw_len_s = burst_len[int'(pick_idx_s)*LENW +: LENW];
        if (raw_len_s == LENW'(0)) begin
            pick_len_s = LENW'(1);
        end else if (raw_len_s > LENW'(BURST_MAX)) begin
            pick_len_s = LENW'(BURST_MAX);
        end else begin
            pick_len_s = raw_len_s;
        end
    end

    // Scheduler next-state: grant in IDLE, count accepted beats in BURST, release and advance pointer.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        valid_d = valid_q;
        last_d  = last_q;
        rr_d    = rr_q;
        owner_d = owner_q;
        beats_d = beats_q;
        case (state_q)
            IDLE: begin
                if (seed_load) begin
                    state_d = IDLE;
                end else if (pick_found_s) begin
                    state_d = BURST;
                    gnt_d   = NREQ'(1) << pick_idx_s;
                    valid_d = 1'b1;
                    last_d  = (pick_len_s == LENW'(1));
                    owner_d = pick_idx_s;
                    beats_d = pick_len_s;
                end else begin
                    state_d = IDLE;
                end
            end
            BURST: begin
                if (accept_s) begin
                    if (beats_q == LENW'(1)) begin
                        state_d = IDLE;
                        gnt_d   = '0;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        beats_d = '0;
                        if (owner_q == IW'(NREQ - 1)) begin
                            rr_d = '0;
                        end else begin
                            rr_d = owner_q + IW'(1);
                        end
                    end else begin
                        beats_d = beats_q - LENW'(1);
                        last_d  = (beats_q == LENW'(2));
                    end
                end else begin
                    state_d = BURST;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                valid_d = 1'b0;
                last_d  = 1'b0;
            end
        endcase
        busy_d = (state_d == BURST);
    end

    // Wrap counter: counts accepted terminal words, saturating.
    always_comb begin
        if (accept_s && term_s && (wrap_q != 16'hFFFF)) begin
            wrap_d = wrap_q + 16'd1;
        end else begin
            wrap_d = wrap_q;
        end
    end

    // Scheduler FSM and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            rr_q    <= '0;
            owner_q <= '0;
            beats_q <= '0;
            wrap_q  <= 16'd0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            rr_q    <= rr_d;
            owner_q <= owner_d;
            beats_q <= beats_d;
            wrap_q  <= wrap_d;
        end
    end

    assign gnt        = gnt_q;
    assign rd_valid   = valid_q;
    assign rd_last    = last_q;
    assign rd_data    = gen_q_s;
    assign busy       = busy_q;
    assign wrap_count = wrap_q;

endmodule

// File: tb/tb_lfsr_rr_scheduler.sv
// Self-checking bench for lfsr_rr_scheduler: directed scenarios plus random traffic against a behavioural model.
module tb_lfsr_rr_scheduler;

    localparam int          NREQ      = 4;
    localparam int          WIDTH     = 64;
    localparam int          BURST_MAX = 8;
    localparam int          LENW      = 4;
    localparam logic [63:0] SEED      = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] TERM      = 64'h9C69_8321_9672_4182;

    logic                 clock = 1'b0;
    logic                 reset;
    logic [NREQ-1:0]      req;
    logic [NREQ*LENW-1:0] burst_len;
    logic [NREQ-1:0]      gnt;
    logic                 rd_valid;
    logic                 rd_ready;
    logic [WIDTH-1:0]     rd_data;
    logic                 rd_last;
    logic                 seed_load;
    logic [WIDTH-1:0]     seed_value;
    logic                 busy;
    logic [15:0]          wrap_count;

    int checks = 0;
    int errors = 0;

    // Behavioural model: owner index (-1 = idle), words left, pointer, generator, wraps.
    int          m_owner;
    int          m_left;
    int          m_rr;
    int          m_wrap;
    logic [63:0] m_gen;

    logic [NREQ-1:0] gq[$];
    logic [NREQ-1:0] exp_order [5];
    logic [63:0]     d0;
    logic [NREQ-1:0] g0;
    int              acc;

    always #5 clock = ~clock;

    lfsr_rr_scheduler dut (
        .clock      (clock),
        .reset      (reset),
        .req        (req),
        .burst_len  (burst_len),
        .gnt        (gnt),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .rd_data    (rd_data),
        .rd_last    (rd_last),
        .seed_load  (seed_load),
        .seed_value (seed_value),
        .busy       (busy),
        .wrap_count (wrap_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Generator rule as arithmetic: rotate left by one, then overwrite the top nibble with adjacent XORs.
    function automatic logic [63:0] gen_next(input logic [63:0] q);
        logic [63:0] rot;
        logic [3:0]  nib;
        rot = (q << 1) | (q >> 63);
        nib = 4'((q >> 59) ^ (q >> 58));
        return {nib, rot[59:0]};
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_left  = 0;
        m_rr    = 0;
        m_wrap  = 0;
        m_gen   = SEED;
    endtask

    // Effect of the coming clock edge given the inputs currently driven.
    task automatic model_edge();
        int l;
        bit found;
        if (m_owner < 0) begin
            if (seed_load) begin
                m_gen = (seed_value == 64'd0) ? SEED : seed_value;
            end else if (req != '0) begin
                found = 1'b0;
                for (int k = 0; k < NREQ; k++) begin
                    if (!found && req[(m_rr + k) % NREQ]) begin
                        found   = 1'b1;
                        m_owner = (m_rr + k) % NREQ;
                    end
                end
                l = int'(burst_len[m_owner*LENW +: LENW]);
                m_left = (l == 0) ? 1 : ((l > BURST_MAX) ? BURST_MAX : l);
            end
        end else if (rd_ready) begin
            if (m_gen == TERM) begin
                m_gen = SEED;
                if (m_wrap < 65535) m_wrap++;
            end else begin
                m_gen = gen_next(m_gen);
            end
            m_left--;
            if (m_left == 0) begin
                m_rr    = (m_owner + 1) % NREQ;
                m_owner = -1;
            end
        end
    endtask

    task automatic check_all();
        chk("gnt",        64'(gnt),        (m_owner < 0) ? 64'd0 : (64'd1 << m_owner));
        chk("rd_valid",   64'(rd_valid),   64'(m_owner >= 0));
        chk("rd_last",    64'(rd_last),    64'(m_owner >= 0 && m_left == 1));
        chk("rd_data",    rd_data,         m_gen);
        chk("busy",       64'(busy),       64'(m_owner >= 0));
        chk("wrap_count", 64'(wrap_count), 64'(m_wrap));
    endtask

    task automatic step();
        model_edge();
        @(posedge clock);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        model_reset();
        check_all();
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    // Consume the current burst with rd_ready high; returns the number of accepted words.
    task automatic run_burst(output int n);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (rd_valid && rd_ready) n++;
            step();
            if (!rd_valid) break;
        end
    endtask

    initial begin
        exp_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        reset      = 1'b1;
        req        = '0;
        burst_len  = '0;
        rd_ready   = 1'b0;
        seed_load  = 1'b0;
        seed_value = '0;
        model_reset();
        @(posedge clock);
        #1;
        check_all();
        chk("reset_data", rd_data, SEED);
        reset = 1'b0;

        // 1: two-word burst for requester 0
        req = 4'b0001; burst_len = 16'h0002; rd_ready = 1'b1;
        step();
        chk("t1_gnt", 64'(gnt), 64'd1);
        chk("t1_w0", rd_data, SEED);
        req = 4'b0000;
        step();
        chk("t1_w1", rd_data, 64'h0FFF_FFFF_FFFF_FFFF);
        chk("t1_last", 64'(rd_last), 64'd1);
        step();
        chk("t1_idle", 64'({gnt, busy}), 64'd0);

        // 2: all requesting, single-word bursts, round-robin order
        do_reset();
        req = 4'b1111; burst_len = 16'h1111;
        for (int i = 0; i < 10; i++) begin
            step();
            if (gnt != '0) gq.push_back(gnt);
        end
        chk("t2_ngrants", 64'(gq.size()), 64'd5);
        for (int i = 0; i < 5; i++) begin
            if (i < gq.size()) chk("t2_order", 64'(gq[i]), 64'(exp_order[i]));
        end
        req = 4'b0000;
        step();

        // 3: three-word burst with a five-cycle stall after the first word
        req = 4'b0100; burst_len = 16'h0300; rd_ready = 1'b0;
        step();
        d0 = rd_data; g0 = gnt;
        req = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t3_stall_data", rd_data, d0);
            chk("t3_stall_gnt", 64'(gnt), 64'(g0));
        end
        rd_ready = 1'b1;
        run_burst(acc);
        chk("t3_accepts", 64'(acc), 64'd3);

        // 4: zero seed together with a request, then terminal-word wrap
        req = 4'b0001; burst_len = 16'h0001; seed_load = 1'b1; seed_value = 64'd0;
        step();
        chk("t4_seed", rd_data, SEED);
        chk("t4_nognt", 64'(gnt), 64'd0);
        seed_load = 1'b0;
        step();
        chk("t4_gnt", 64'(gnt), 64'd1);
        chk("t4_w0", rd_data, SEED);
        req = 4'b0000;
        step();
        seed_load = 1'b1; seed_value = TERM;
        step();
        chk("t4_term", rd_data, TERM);
        seed_load = 1'b0; req = 4'b0001;
        step();
        req = 4'b0000;
        step();
        chk("t4_reload", rd_data, SEED);
        chk("t4_wrap", 64'(wrap_count), 64'd1);

        // 5: reset in the middle of a four-word burst
        req = 4'b0010; burst_len = 16'h0040;
        step();
        step();
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_all();
        chk("t5_drop", 64'({gnt, rd_valid, rd_last}), 64'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        req = 4'b1001; burst_len = 16'h0001;
        step();
        chk("t5_rr0", 64'(gnt), 64'd1);
        chk("t5_data", rd_data, SEED);
        req = 4'b0000;
        step();

        // 6: length 0 means one word, length 15 clamps to BURST_MAX
        req = 4'b0001; burst_len = 16'h0000;
        step();
        req = 4'b0000;
        run_burst(acc);
        chk("t6_len0", 64'(acc), 64'd1);
        req = 4'b0001; burst_len = 16'h000F;
        step();
        req = 4'b0000;
        run_burst(acc);
        chk("t6_len15", 64'(acc), 64'(BURST_MAX));

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            req       = 4'($urandom);
            burst_len = 16'($urandom);
            rd_ready  = ($urandom_range(0, 3) != 0);
            seed_load = ($urandom_range(0, 19) == 0);
            case ($urandom_range(0, 2))
                0:       seed_value = 64'd0;
                1:       seed_value = TERM;
                default: seed_value = {$urandom, $urandom};
            endcase
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lfsr_rr_scheduler.md
Name: lfsr_rr_scheduler

Overview:
Shares one 64-bit pseudo-random generator between NREQ requesters using round-robin arbitration. Each grant is a burst of 1..BURST_MAX words, delivered over a valid/ready read channel. The generator advances only when a word is consumed, so no random word is handed to two requesters. The block sits between the random-stimulus/scrambler clients and the generator core, and also owns seeding and wrap-around accounting.

Parameters:
NREQ, 4, number of requesters (2..8)
WIDTH, 64, generator/data width (fixed 64 for the current tap set)
BURST_MAX, 8, maximum words per grant
LENW, 4, width of each per-requester length field (must hold BURST_MAX)
SEED, 64'hFFFF_FFFF_FFFF_FFFF, reset/reload value of the generator

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
req  in  NREQ  per-requester request level
burst_len  in  NREQ*LENW  requester i length at [i*LENW +: LENW]; 0 treated as 1, >BURST_MAX clamped to BURST_MAX
gnt  out  NREQ  one-hot owner of current burst, 0 when idle
rd_valid  out  1  word available
rd_ready  in  1  consumer accepts word
rd_data  out  WIDTH  current generator word
rd_last  out  1  final word of the burst
seed_load  in  1  load seed_value into generator (honoured in IDLE only)
seed_value  in  WIDTH  seed; 0 replaced by SEED (avoids lock-up)
busy  out  1  state != IDLE
wrap_count  out  16  terminal-state reloads since reset, saturating at 16'hFFFF

Behaviour:
- Reset (async, any time, including mid-burst): state=IDLE, gnt=0, rd_valid=0, rd_last=0, rr pointer=0, beat counter=0, generator=SEED (rd_data=SEED), wrap_count=0. No rd_last is emitted for an aborted burst.
- States: IDLE, BURST.
- IDLE:
  - seed_load=1: generator<=seed_value (or SEED if 0); stay IDLE; req is ignored this cycle.
  - Else, any req: pick first requester with req=1, searching from the rr pointer upward with modulo-NREQ wrap. Register gnt one-hot, beats<=clamped len, go to BURST.
  - Latency: req sampled at edge N gives gnt and rd_valid high after edge N.
- BURST:
  - rd_valid=1, gnt held, rd_last=(beats==1).
  - On rd_valid&rd_ready: generator steps once, beats decrements.
  - Stall (rd_ready=0): rd_data, gnt and rd_last are held stable.
  - Last accepted beat: rr pointer<=granted index+1 mod NREQ, gnt<=0, rd_valid<=0, go to IDLE. This gives one mandatory idle cycle between bursts.
  - Requester dropping req mid-burst: ignored; the burst completes.
  - seed_load in BURST: ignored (callers poll busy).
- Generator step: next = {q[62]^q[61], q[61]^q[60], q[60]^q[59], q[59]^q[58], q[58:0], q[63]}.
- Terminal word TERM=64'h9C69_8321_9672_4182:
  - If accepted, the next generator value is SEED instead of the step result.
  - wrap_count increments on that same edge, saturating at 16'hFFFF.
  - Terminal state is evaluated only on accepted beats.
- Simultaneous seed_load and req in IDLE: seed wins; grant follows one cycle later if req is still high.
- rr pointer moves only on burst completion, never on reset-free idle cycles.

Decomposition:
- Package lfsr_sched_pkg:
  - state enum (IDLE, BURST)
  - TERM constant
  - default SEED
  - step function for the tap set
- Sub-module lfsr64_core, one instance:
  - Inputs: clock, reset, step_en, load_en, load_val.
  - Outputs: q, term (q==TERM).
  - Reload to SEED on step_en&term.
  - The scheduler holds the FSM, round-robin pointer, beat counter and wrap counter.

Test Plan:
1. Reset release; req=4'b0001, len0=2, rd_ready=1 → rd_valid one cycle later; words FFFF_FFFF_FFFF_FFFF then 0FFF_FFFF_FFFF_FFFF; rd_last on the 2nd word; gnt=0001 then 0 and busy=0 the next cycle.
2. req=4'b1111 held, all len=1, rd_ready=1 → grant order 0,1,2,3,0 with one idle cycle between grants; generator advances exactly one step per grant.
3. Burst len=3 with rd_ready low for 5 cycles after the first word → rd_data and gnt unchanged during the stall; exactly 3 accepts; rd_last only on the 3rd.
4. seed_load=1, seed_value=0 in IDLE with req=0001 in the same cycle → generator=SEED; grant 2 cycles after; first word FFFF_FFFF_FFFF_FFFF. Then seed_value=TERM loaded and one word consumed → next word FFFF_FFFF_FFFF_FFFF and wrap_count=1.
5. Assert reset mid-burst (beat 2 of 4) → gnt, rd_valid and rd_last drop immediately; after release the rr pointer=0 and the first word=SEED.
6. len=0 and len=15 (BURST_MAX=8) → bursts of exactly 1 and 8 words respectively.
